// File: rtl/dot_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dot_pipe_if                                                  |
// | Description : Vector-in / result-out handshake bundle for dot_pipe.        |
// |               The master side drives vectors and consumes results. The     |
// |               slave side is the dot-product pipeline.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface dot_pipe_if #(
  parameter int N  = 3,
  parameter int W  = 8,
  parameter int OW = 2*W+4
);
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  a;
  logic [N*W-1:0]  b;
  logic [W-1:0]    c;
  logic            acc_mode;
  logic            acc_last;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   y;

  modport master (
    output in_valid, a, b, c, acc_mode, acc_last, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, c, acc_mode, acc_last, out_ready,
    output in_ready, out_valid, y
  );
endinterface
`default_nettype wire

// File: rtl/dot_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dot_pipe                                                     |
// | Description : N-term multiply-add pipeline, y = sum a_i*b_i + c, with a     |
// |               valid/ready handshake, global stall on backpressure and a    |
// |               multi-beat accumulate mode. Arithmetic wraps at OW bits.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dot_pipe #(
  parameter int N      = 3,
  parameter int W      = 8,
  parameter int OW     = 2*W+4,
  parameter int SIGNED = 0
) (
  input  logic       clk,
  input  logic       reset,
  dot_pipe_if.slave  bus
);

  // Widen an operand to the result width, sign- or zero-extended.
  function automatic logic [OW-1:0] ext(input logic [W-1:0] v);
    if (SIGNED != 0) ext = {{(OW-W){v[W-1]}}, v};
    else             ext = {{(OW-W){1'b0}}, v};
  endfunction

  // Stage 0 holds the raw beat; stage k (1..N) holds the running sum after k
  // products. The operand vectors only need to travel as far as stage N-1.
  logic            v_q    [0:N];
  logic            mode_q [0:N];
  logic            last_q [0:N];
  logic [N*W-1:0]  a_q    [0:N-1];
  logic [N*W-1:0]  b_q    [0:N-1];
  logic [OW-1:0]   sum_q  [0:N];

  logic            en;
  logic [OW-1:0]   acc_q, acc_d;
  logic            acc_active_q, acc_active_d;
  logic [OW-1:0]   y_q, y_d;
  logic            out_valid_q, out_valid_d;
  logic [OW-1:0]   acc_base;

  // One stall signal for the whole pipe: everything moves only when the
  // output register is empty or being drained this cycle.
  assign en            = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = en && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign acc_base      = acc_active_q ? acc_q : '0;

  // Input capture and the multiply-add chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= N; k++) begin
        v_q[k]    <= 1'b0;
        mode_q[k] <= 1'b0;
        last_q[k] <= 1'b0;
        sum_q[k]  <= '0;
      end
      for (int k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0]    <= bus.in_valid;
      mode_q[0] <= bus.acc_mode;
      last_q[0] <= bus.acc_last;
      a_q[0]    <= bus.a;
      b_q[0]    <= bus.b;
      sum_q[0]  <= ext(bus.c);
      for (int k = 1; k <= N; k++) begin
        v_q[k]    <= v_q[k-1];
        mode_q[k] <= mode_q[k-1];
        last_q[k] <= last_q[k-1];
        sum_q[k]  <= sum_q[k-1]
                   + ext(a_q[k-1][(k-1)*W +: W]) * ext(b_q[k-1][(k-1)*W +: W]);
      end
      for (int k = 1; k < N; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end
  end

  // Output/accumulate stage next-state: emit, fold into acc, or close a run.
  always_comb begin
    acc_d        = acc_q;
    acc_active_d = acc_active_q;
    y_d          = y_q;
    out_valid_d  = out_valid_q;
    if (en) begin
      // Reaching here with out_valid high means the consumer took y this edge.
      out_valid_d = 1'b0;
      if (v_q[N]) begin
        if (!mode_q[N]) begin
          // Plain beat: does not touch an accumulation in progress.
          y_d         = sum_q[N];
          out_valid_d = 1'b1;
        end else if (!last_q[N]) begin
          acc_d        = acc_base + sum_q[N];
          acc_active_d = 1'b1;
        end else begin
          y_d          = acc_base + sum_q[N];
          out_valid_d  = 1'b1;
          acc_d        = '0;
          acc_active_d = 1'b0;
        end
      end
    end
  end

  // Output/accumulate stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      acc_active_q <= 1'b0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_active_q <= acc_active_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dot_pipe                                                  |
// | Description : Directed self-checking bench for dot_pipe with a result      |
// |               scoreboard (unsigned instance) and a signed instance.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dot_pipe;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int OW = 2*W+4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dot_pipe_if #(.N(N), .W(W), .OW(OW)) bus   ();
  dot_pipe_if #(.N(N), .W(W), .OW(OW)) bus_s ();

  dot_pipe #(.N(N), .W(W), .OW(OW), .SIGNED(0)) u_dut   (.clk(clk), .reset(reset), .bus(bus));
  dot_pipe #(.N(N), .W(W), .OW(OW), .SIGNED(1)) u_dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [OW-1:0] exp_q [$];
  int            out_cyc [$];
  logic [OW-1:0] last_y;
  logic [OW-1:0] m_acc;
  bit            m_active;

  // Reference dot product in wide integer arithmetic, truncated to OW bits.
  function automatic logic [OW-1:0] dot_ref(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                            input logic [W-1:0] c, input bit sgn);
    longint     s;
    logic [W-1:0] ai, bi;
    s = sgn ? longint'($signed(c)) : longint'(c);
    for (int i = 0; i < N; i++) begin
      ai = a[i*W +: W];
      bi = b[i*W +: W];
      s += (sgn ? longint'($signed(ai)) : longint'(ai)) *
           (sgn ? longint'($signed(bi)) : longint'(bi));
    end
    return s[OW-1:0];
  endfunction

  function automatic logic [N*W-1:0] pack3(input int x0, input int x1, input int x2);
    logic [W-1:0] e0, e1, e2;
    e0 = W'(x0); e1 = W'(x1); e2 = W'(x2);
    return {e2, e1, e0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance, update the reference model.
  task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                      input logic [W-1:0] c, input logic m, input logic l);
    int            t;
    logic [OW-1:0] d;
    t = 0;
    bus.a = a; bus.b = b; bus.c = c; bus.acc_mode = m; bus.acc_last = l;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 200) begin step(); t++; end
    chk("send_ready", 64'(bus.in_ready), 64'd1);
    d = dot_ref(a, b, c, 1'b0);
    if (!m) exp_q.push_back(d);
    else if (!l) begin
      m_acc    = (m_active ? m_acc : '0) + d;
      m_active = 1'b1;
    end else begin
      exp_q.push_back((m_active ? m_acc : '0) + d);
      m_acc    = '0;
      m_active = 1'b0;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin step(); t++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) step();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a transfer happens on the next edge when valid and ready are
  // both high mid-cycle.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      out_cyc.push_back(cyc);
      last_y = bus.y;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0d expected=none", bus.y);
      end
      if (exp_q.size() != 0) begin
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (bus.y === e) else begin
          errors++;
          $error("FAIL sb_y observed=%0d expected=%0d", bus.y, e);
        end
      end
    end
  end

  initial begin
    int            lat;
    int            n0;
    logic [OW-1:0] y0;
    logic [N*W-1:0] ra, rb;
    logic [W-1:0]  rc;

    reset = 1'b1;
    m_acc = '0; m_active = 1'b0;
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.c = '0;
    bus.acc_mode = 0; bus.acc_last = 0; bus.out_ready = 1;
    bus_s.in_valid = 0; bus_s.a = '0; bus_s.b = '0; bus_s.c = '0;
    bus_s.acc_mode = 0; bus_s.acc_last = 0; bus_s.out_ready = 1;
    step(); step();

    // Reset state
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_y",         64'(bus.y),         64'd0);
    chk("rst_s_y",       64'(bus_s.y),       64'd0);
    reset = 1'b0;
    step();
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Unsigned single beat and latency (accept edge counts as edge 1)
    send(pack3(1, 2, 3), pack3(4, 5, 6), 8'd7, 1'b0, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin step(); lat++; end
    chk("latency", 64'(lat), 64'd5);
    chk("single_y", 64'(bus.y), 64'd39);
    drain();

    // Signed instance: -4 - 10 - 18 - 2 = -34
    bus_s.a = pack3(-1, 2, -3); bus_s.b = pack3(4, -5, 6); bus_s.c = 8'hFE;
    bus_s.in_valid = 1'b1;
    step();
    bus_s.in_valid = 1'b0;
    lat = 1;
    while (!bus_s.out_valid && lat < 20) begin step(); lat++; end
    chk("signed_latency", 64'(lat), 64'd5);
    chk("signed_y",       64'(bus_s.y), 64'(20'hFFFDE));
    chk("signed_model",   64'(bus_s.y), 64'(dot_ref(pack3(-1, 2, -3), pack3(4, -5, 6), 8'hFE, 1'b1)));
    step();

    // Streaming: 8 back-to-back beats
    out_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
      ra = (N*W)'($urandom()); rb = (N*W)'($urandom()); rc = W'($urandom());
      send(ra, rb, rc, 1'b0, 1'b0);
    end
    drain();
    chk("stream_count", 64'(out_cyc.size()), 64'd8);
    if (out_cyc.size() == 8) chk("stream_no_bubble", 64'(out_cyc[7] - out_cyc[0]), 64'd7);

    // Backpressure: results pending with out_ready low for 4 cycles
    out_cyc.delete();
    bus.out_ready = 1'b0;
    send(pack3(9, 8, 7), pack3(1, 2, 3), 8'd5, 1'b0, 1'b0);
    send(pack3(10, 20, 30), pack3(3, 3, 3), 8'd1, 1'b0, 1'b0);
    send(pack3(255, 0, 1), pack3(2, 0, 255), 8'd0, 1'b0, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin step(); lat++; end
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    y0 = bus.y;
    repeat (4) begin
      step();
      chk("bp_y_hold",    64'(bus.y),        64'(y0));
      chk("bp_in_ready",  64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    drain();
    chk("bp_count", 64'(out_cyc.size()), 64'd3);

    // Accumulate two beats: 32 + 32
    n0 = out_cyc.size();
    send(pack3(1, 2, 3), pack3(4, 5, 6), 8'd0, 1'b1, 1'b0);
    send(pack3(1, 2, 3), pack3(4, 5, 6), 8'd0, 1'b1, 1'b1);
    drain();
    chk("acc_count", 64'(out_cyc.size() - n0), 64'd1);
    chk("acc_y",     64'(last_y), 64'd64);

    // Plain beat inside an accumulation emits alone; acc continues
    n0 = out_cyc.size();
    send(pack3(1, 2, 3), pack3(4, 5, 6), 8'd0, 1'b1, 1'b0);
    send(pack3(2, 0, 0), pack3(3, 0, 0), 8'd1, 1'b0, 1'b0);
    send(pack3(1, 2, 3), pack3(4, 5, 6), 8'd0, 1'b1, 1'b1);
    drain();
    chk("mix_count", 64'(out_cyc.size() - n0), 64'd2);
    chk("mix_y",     64'(last_y), 64'd64);

    // Wrap at OW bits: 6 * 195330 mod 2^20
    for (int i = 0; i < 6; i++)
      send(pack3(255, 255, 255), pack3(255, 255, 255), 8'd255, 1'b1, (i == 5) ? 1'b1 : 1'b0);
    drain();
    chk("wrap_y", 64'(last_y), 64'd123404);

    // Reset after a partial accumulation has been folded in
    out_cyc.delete();
    send(pack3(1, 2, 3), pack3(4, 5, 6), 8'd0, 1'b1, 1'b0);
    repeat (8) step();
    reset = 1'b1;
    step();
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    reset = 1'b0;
    exp_q.delete();
    m_acc = '0; m_active = 1'b0;
    step();
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    send(pack3(1, 2, 3), pack3(4, 5, 6), 8'd0, 1'b1, 1'b1);
    drain();
    chk("midrst_count", 64'(out_cyc.size()), 64'd1);
    chk("midrst_y",     64'(last_y), 64'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
